spi_master: RTL and testbench

SPI initiator that drives the serial clock and MOSI line and samples MISO, forming the opposite end of the link to the team's `SPIReader` responder. A parallel byte is accepted on a valid/ready handshake, shifted out MSB-first on `mosi` while the response byte is shifted in from `miso`. The received byte is presented with a one-cycle valid pulse. The block sits in the host-side logic that talks to the camera/sensor board over the same four-signal link (`spi_clk`, `mosi`, `miso`, plus an optional select).

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_master_if.sv | 29 ++
 rtl/spi_phase_timer.sv | 17 +
 rtl/spi_master.sv | 114 +++++++++++
 tb/tb_spi_master.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared types and widths for the SPI master and its phase timer.
package spi_pkg;
  localparam int SPI_FRAME_BITS = 8;
  localparam int SPI_DIV_W      = 8;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, GAP} spi_master_state_t;
endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: byte handshake plus serial link of spi_master; cs_n exists only with SPI_MASTER_CS_EN.
interface spi_master_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       spi_clk;
  logic       mosi;
  logic       miso;
`ifdef SPI_MASTER_CS_EN
  logic       cs_n;
`endif
  modport master (
    input  tx_data, tx_valid, miso,
`ifdef SPI_MASTER_CS_EN
    output cs_n,
`endif
    output tx_ready, rx_data, rx_valid, busy, spi_clk, mosi
  );
  modport slave (
    output tx_data, tx_valid, miso,
`ifdef SPI_MASTER_CS_EN
    input  cs_n,
`endif
    input  tx_ready, rx_data, rx_valid, busy, spi_clk, mosi
  );
endinterface

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable down-counter whose done flags the last cycle of a phase.
module spi_phase_timer
  import spi_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [SPI_DIV_W-1:0] len_i,
  output logic                 done_o
);
  logic [SPI_DIV_W-1:0] cnt_q, cnt_d;
  assign done_o = cnt_q == '0;
  always_comb cnt_d = load_i ? len_i - 1'b1 : (done_o ? cnt_q : cnt_q - 1'b1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator exchanging one byte MSB-first per handshake.
// Define SPI_MASTER_CS_EN to add an active-low cs_n and a one-phase setup before bit 0.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  spi_master_if.master bus
);
  localparam logic [SPI_DIV_W-1:0] DIV_LEN  = SPI_DIV_W'(CLK_DIV);
  localparam logic [SPI_DIV_W-1:0] GAP_LEN  = SPI_DIV_W'(GAP_CYCLES == 0 ? 1 : GAP_CYCLES);
  localparam logic [2:0]           LAST_BIT = 3'(SPI_FRAME_BITS - 1);
  spi_master_state_t         state_q, state_d;
  logic [SPI_FRAME_BITS-1:0] sh_q, sh_d, rx_data_q, rx_data_d;
  logic [2:0]                bit_q, bit_d;
  logic                      rx_valid_q, rx_valid_d, spi_clk_q, mosi_q, tx_ready_q;
  logic                      load, done, active_d;
  logic [SPI_DIV_W-1:0]      len;
`ifdef SPI_MASTER_CS_EN
  logic                      setup_q, setup_d, cs_n_q;
`endif
  spi_phase_timer u_timer (.clk(clk), .rst(rst), .load_i(load), .len_i(len), .done_o(done));
  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    bit_d      = bit_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    load       = 1'b0;
    len        = DIV_LEN;
`ifdef SPI_MASTER_CS_EN
    setup_d    = setup_q;
`endif
    case (state_q)
      IDLE: if (bus.tx_valid) begin
        state_d = LOW;
        sh_d    = bus.tx_data;
        bit_d   = '0;
        load    = 1'b1;
`ifdef SPI_MASTER_CS_EN
        setup_d = 1'b1;
`endif
      end
      LOW: if (done) begin
        load = 1'b1;
`ifdef SPI_MASTER_CS_EN
        if (setup_q) setup_d = 1'b0;
        else         state_d = HIGH;
`else
        state_d = HIGH;
`endif
      end
      HIGH: if (done) begin
        // sample late in the high phase so the responder has seen the rising edge
        sh_d = {sh_q[SPI_FRAME_BITS-2:0], bus.miso};
        load = 1'b1;
        if (bit_q == LAST_BIT) begin
          state_d    = GAP;
          rx_data_d  = sh_d;
          rx_valid_d = 1'b1;
          len        = GAP_LEN;
        end else begin
          state_d = LOW;
          bit_d   = bit_q + 3'd1;
        end
      end
      GAP: if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    active_d = state_d == LOW || state_d == HIGH;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bit_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      spi_clk_q  <= 1'b0;
      mosi_q     <= 1'b0;
      tx_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      spi_clk_q  <= state_d == HIGH;
      mosi_q     <= active_d & sh_d[SPI_FRAME_BITS-1];
      tx_ready_q <= state_d == IDLE;
    end
  end
`ifdef SPI_MASTER_CS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      setup_q <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      setup_q <= setup_d;
      cs_n_q  <= !(active_d || rx_valid_d);
    end
  end
  assign bus.cs_n = cs_n_q;
`endif
  assign bus.tx_ready = tx_ready_q;
  assign bus.busy     = !tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.spi_clk  = spi_clk_q;
  assign bus.mosi     = mosi_q;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard bench for spi_master (D=2/GAP=4 with a miso model, D=3/GAP=0 in loopback).
module tb_spi_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if m2();
  spi_master_if m3();
  spi_master #(.CLK_DIV(2), .GAP_CYCLES(4)) u_d2 (.clk(clk), .rst(rst), .bus(m2.master));
  spi_master #(.CLK_DIV(3), .GAP_CYCLES(0)) u_d3 (.clk(clk), .rst(rst), .bus(m3.master));

`ifdef SPI_MASTER_CS_EN
  localparam int S2 = 2;
  localparam int S3 = 3;
`else
  localparam int S2 = 0;
  localparam int S3 = 0;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp2_q[$];
  logic [7:0] exp3_q[$];

  // responder model: presents resp2 MSB-first, advancing on each spi_clk falling edge
  logic [7:0] resp2 = 8'h00;
  int fall2 = 0;
  int base2 = 0;
  int idx2;
  always @(negedge m2.spi_clk) fall2++;
  always_comb begin
    idx2 = fall2 - base2;
    m2.miso = (idx2 >= 0 && idx2 < 8) ? resp2[3'(7 - idx2)] : 1'b0;
  end
  assign m3.miso = m3.mosi;

  task automatic test_reset();
    int bad;
    m2.tx_valid = 1'b0; m2.tx_data = 8'h00;
    m3.tx_valid = 1'b0; m3.tx_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m2.spi_clk, m2.mosi, m2.tx_ready, m2.busy, m2.rx_valid, m2.rx_data} !== {4'b0010, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_d2: clk/mosi/rdy/busy/rxv/rxd=%b%b%b%b%b %h, required 0010 0 00",
               m2.spi_clk, m2.mosi, m2.tx_ready, m2.busy, m2.rx_valid, m2.rx_data);
    end
    checks++;
    if ({m3.spi_clk, m3.mosi, m3.tx_ready, m3.busy, m3.rx_valid, m3.rx_data} !== {4'b0010, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_d3: clk/mosi/rdy/busy/rxv/rxd=%b%b%b%b%b %h, required 0010 0 00",
               m3.spi_clk, m3.mosi, m3.tx_ready, m3.busy, m3.rx_valid, m3.rx_data);
    end
`ifdef SPI_MASTER_CS_EN
    checks++;
    if (m2.cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n: cs_n=%b, required 1", m2.cs_n); end
`endif
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (m2.rx_valid !== 1'b0 || m2.spi_clk !== 1'b0 || m2.mosi !== 1'b0 || m2.tx_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL reset_idle: %0d bad idle cycles, required 0", bad); end
  endtask

  task automatic test_frame_d2();
    int rx_at = -1, rdy_at = -1, pulses = 0, rises = 0;
    logic prev;
    logic [7:0] mo = '0, e;
    @(negedge clk);
    resp2 = 8'hAB; base2 = fall2; exp2_q.push_back(8'hAB);
    m2.tx_data = 8'hCB; m2.tx_valid = 1'b1; prev = m2.spi_clk;
    for (int n = 1; n <= 200 && rdy_at < 0; n++) begin
      @(negedge clk);
      m2.tx_valid = 1'b0;
      if (n == 1) begin
        checks++;
        if (m2.busy !== 1'b1 || m2.tx_ready !== 1'b0) begin
          errors++; $display("FAIL d2_busy: busy=%b tx_ready=%b, required 1 0", m2.busy, m2.tx_ready);
        end
      end
      if (m2.spi_clk && !prev) begin mo = {mo[6:0], m2.mosi}; rises++; end
      prev = m2.spi_clk;
      if (m2.rx_valid) begin
        pulses++;
        if (rx_at < 0) begin
          rx_at = n;
          e = exp2_q.size() > 0 ? exp2_q.pop_front() : 8'hxx;
          checks++;
          if (m2.rx_data !== e) begin errors++; $display("FAIL d2_rx_data: got %h, required %h", m2.rx_data, e); end
        end
      end
      if (m2.tx_ready) rdy_at = n;
    end
    checks++;
    if (rises !== 8 || mo !== 8'hCB) begin errors++; $display("FAIL d2_mosi: %0d rises bits %h, required 8 cb", rises, mo); end
    checks++;
    if (rx_at !== 33 + S2) begin errors++; $display("FAIL d2_rx_cycle: T+%0d, required T+%0d", rx_at, 33 + S2); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL d2_rx_pulse: %0d cycles, required 1", pulses); end
    checks++;
    if (rdy_at !== 37 + S2) begin errors++; $display("FAIL d2_ready_cycle: T+%0d, required T+%0d", rdy_at, 37 + S2); end
    checks++;
    if (m2.rx_data !== 8'hAB) begin errors++; $display("FAIL d2_rx_hold: %h, required ab", m2.rx_data); end
  endtask

  task automatic test_loopback_d3();
    int rx_at = -1, rdy_at = -1, pulses = 0, rises = 0;
    logic prev;
    logic [7:0] mo = '0, e;
    @(negedge clk);
    exp3_q.push_back(8'h5A);
    m3.tx_data = 8'h5A; m3.tx_valid = 1'b1; prev = m3.spi_clk;
    for (int n = 1; n <= 200 && rdy_at < 0; n++) begin
      @(negedge clk);
      m3.tx_valid = 1'b0;
      if (m3.spi_clk && !prev) begin mo = {mo[6:0], m3.mosi}; rises++; end
      prev = m3.spi_clk;
      if (m3.rx_valid) begin
        pulses++;
        if (rx_at < 0) begin
          rx_at = n;
          e = exp3_q.size() > 0 ? exp3_q.pop_front() : 8'hxx;
          checks++;
          if (m3.rx_data !== e) begin errors++; $display("FAIL d3_rx_data: got %h, required %h", m3.rx_data, e); end
        end
      end
      if (m3.tx_ready) rdy_at = n;
    end
    checks++;
    if (rises !== 8 || mo !== 8'h5A) begin errors++; $display("FAIL d3_mosi: %0d rises bits %h, required 8 5a", rises, mo); end
    checks++;
    if (rx_at !== 49 + S3) begin errors++; $display("FAIL d3_rx_cycle: T+%0d, required T+%0d", rx_at, 49 + S3); end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL d3_rx_pulse: %0d cycles, required 1", pulses); end
    checks++;
    if (rdy_at !== 50 + S3) begin errors++; $display("FAIL d3_ready_gap0: T+%0d, required T+%0d", rdy_at, 50 + S3); end
  endtask

  task automatic test_back_to_back();
    int rx1 = -1, rx2 = -1, rdy1 = -1, rdy2 = -1, extra = 0, rises = 0;
    logic prev;
    logic [15:0] mo = '0;
    logic [7:0] e;
    @(negedge clk);
    resp2 = 8'h3C; base2 = fall2; exp2_q.push_back(8'h3C);
    m2.tx_data = 8'hF0; m2.tx_valid = 1'b1; prev = m2.spi_clk;
    for (int n = 1; n <= 300 && rdy2 < 0; n++) begin
      @(negedge clk);
      if (n == 1) m2.tx_data = 8'h0F;
      if (rdy1 >= 0 && n > rdy1) m2.tx_valid = 1'b0;
      if (m2.spi_clk && !prev) begin mo = {mo[14:0], m2.mosi}; rises++; end
      prev = m2.spi_clk;
      if (m2.rx_valid) begin
        if (rx1 < 0) rx1 = n; else rx2 = n;
        e = exp2_q.size() > 0 ? exp2_q.pop_front() : 8'hxx;
        checks++;
        if (m2.rx_data !== e) begin errors++; $display("FAIL b2b_rx_data: got %h at T+%0d, required %h", m2.rx_data, n, e); end
      end
      if (m2.tx_ready) begin
        if (rdy1 < 0) begin rdy1 = n; resp2 = 8'hC3; base2 = fall2; exp2_q.push_back(8'hC3); end
        else if (rx2 >= 0) rdy2 = n;
        else extra++;
      end
    end
    checks++;
    if (rdy1 !== 37 + S2) begin errors++; $display("FAIL b2b_first_ready: T+%0d, required T+%0d", rdy1, 37 + S2); end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL b2b_handshake: %0d extra ready cycles, required 0", extra); end
    checks++;
    if (rx2 !== 70 + 2 * S2) begin errors++; $display("FAIL b2b_second_rx: T+%0d, required T+%0d", rx2, 70 + 2 * S2); end
    checks++;
    if (rises !== 16 || mo !== 16'hF00F) begin errors++; $display("FAIL b2b_mosi: %0d rises bits %h, required 16 f00f", rises, mo); end
  endtask

  task automatic test_reset_mid();
    int bad = 0, rx_at = -1, rdy_at = -1, rises = 0;
    logic prev;
    logic [7:0] mo = '0, e;
    @(negedge clk);
    resp2 = 8'hFF; base2 = fall2;
    m2.tx_data = 8'h18; m2.tx_valid = 1'b1;
    for (int n = 1; n <= 19 + S2; n++) begin
      @(negedge clk);
      m2.tx_valid = 1'b0;
    end
    checks++;
    if (m2.spi_clk !== 1'b1 || m2.mosi !== 1'b1) begin
      errors++; $display("FAIL mid_bit4: spi_clk=%b mosi=%b, required 1 1", m2.spi_clk, m2.mosi);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({m2.spi_clk, m2.mosi, m2.tx_ready, m2.rx_valid, m2.rx_data} !== {4'b0010, 8'h00}) begin
      errors++; $display("FAIL mid_async_reset: clk/mosi/rdy/rxv=%b%b%b%b rxd=%h, required 0010 00",
                         m2.spi_clk, m2.mosi, m2.tx_ready, m2.rx_valid, m2.rx_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (m2.rx_valid !== 1'b0 || m2.rx_data !== 8'h00) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL mid_no_rx: %0d cycles with rx activity, required 0", bad); end
    resp2 = 8'h7E; base2 = fall2; exp2_q.push_back(8'h7E);
    m2.tx_data = 8'h81; m2.tx_valid = 1'b1; prev = m2.spi_clk;
    for (int n = 1; n <= 200 && rdy_at < 0; n++) begin
      @(negedge clk);
      m2.tx_valid = 1'b0;
      if (m2.spi_clk && !prev) begin mo = {mo[6:0], m2.mosi}; rises++; end
      prev = m2.spi_clk;
      if (m2.rx_valid && rx_at < 0) begin
        rx_at = n;
        e = exp2_q.size() > 0 ? exp2_q.pop_front() : 8'hxx;
        checks++;
        if (m2.rx_data !== e) begin errors++; $display("FAIL mid_next_rx: got %h, required %h", m2.rx_data, e); end
      end
      if (m2.tx_ready) rdy_at = n;
    end
    checks++;
    if (rx_at !== 33 + S2 || rises !== 8 || mo !== 8'h81) begin
      errors++; $display("FAIL mid_next_frame: rx T+%0d rises %0d bits %h, required T+%0d 8 81", rx_at, rises, mo, 33 + S2);
    end
  endtask

`ifdef SPI_MASTER_CS_EN
  task automatic test_cs();
    int cs_fall = -1, rise1 = -1, rx_at = -1, rdy_at = -1;
    logic prev, cs_rx = 1'bx, cs_after = 1'bx;
    logic [7:0] e;
    @(negedge clk);
    checks++;
    if (m2.cs_n !== 1'b1) begin errors++; $display("FAIL cs_idle: cs_n=%b, required 1", m2.cs_n); end
    resp2 = 8'h5A; base2 = fall2; exp2_q.push_back(8'h5A);
    m2.tx_data = 8'hA5; m2.tx_valid = 1'b1; prev = m2.spi_clk;
    for (int n = 1; n <= 200 && rdy_at < 0; n++) begin
      @(negedge clk);
      m2.tx_valid = 1'b0;
      if (m2.cs_n === 1'b0 && cs_fall < 0) cs_fall = n;
      if (m2.spi_clk && !prev && rise1 < 0) rise1 = n;
      prev = m2.spi_clk;
      if (rx_at >= 0 && n == rx_at + 1) cs_after = m2.cs_n;
      if (m2.rx_valid && rx_at < 0) begin
        rx_at = n; cs_rx = m2.cs_n;
        e = exp2_q.size() > 0 ? exp2_q.pop_front() : 8'hxx;
        checks++;
        if (m2.rx_data !== e) begin errors++; $display("FAIL cs_rx_data: got %h, required %h", m2.rx_data, e); end
      end
      if (m2.tx_ready) rdy_at = n;
    end
    checks++;
    if (cs_fall !== 1 || rise1 !== 5) begin errors++; $display("FAIL cs_setup: cs_n low T+%0d first rise T+%0d, required T+1 T+5", cs_fall, rise1); end
    checks++;
    if (rx_at !== 35 || cs_rx !== 1'b0 || cs_after !== 1'b1) begin
      errors++; $display("FAIL cs_end: rx T+%0d cs_n %b then %b, required T+35 0 then 1", rx_at, cs_rx, cs_after);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame_d2();
    test_loopback_d3();
    test_back_to_back();
    test_reset_mid();
`ifdef SPI_MASTER_CS_EN
    test_cs();
`endif
    checks++;
    if (exp2_q.size() + exp3_q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d bytes never received, required 0", exp2_q.size() + exp3_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
